// File: rtl/seq_alu.sv
// seq_alu: registered MIPS ALU; MULTU/DIVU run as iterative shift-add / restoring ops.
// Define SEQ_ALU_MULDIV_EN to build the multi-cycle multiply/divide datapath.
module seq_alu #(
  parameter int WIDTH = 32,
  localparam int SFT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       con,
  input  logic [WIDTH-1:0] op1,
  input  logic [WIDTH-1:0] op2,
  input  logic [SFT_W-1:0] sft_amt,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             zero,
  output logic             div_by_zero
);

  logic [WIDTH-1:0] alu_res;
  logic             accept;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic             zero_q, zero_d;
  logic             done_q, done_d;

  always_comb begin
    alu_res = '0;
    case (con)
      3'd0:    alu_res = op1 + op2;
      3'd1:    alu_res = op1 - op2;
      3'd2:    alu_res = op1 & op2;
      3'd3:    alu_res = op1 | op2;
      3'd4:    alu_res = op2 << sft_amt;
      3'd5:    alu_res = op2 >> sft_amt;
      default: alu_res = '0;
    endcase
  end

`ifdef SEQ_ALU_MULDIV_EN
  localparam int CNT_W = SFT_W + 1;
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
  logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic             div_q, div_d;
  logic             dbz_q, dbz_d;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_sh;
  logic [WIDTH:0]   div_diff;
  logic [WIDTH-1:0] step_hi, step_lo;
  logic             is_iter;

  assign accept  = start && (state_q == IDLE);
  assign is_iter = con[2] & con[1];

  // One iteration: multiplier / dividend bits stream through acc_lo.
  always_comb begin
    mul_sum  = {1'b0, acc_hi_q}
             + (acc_lo_q[0] ? {1'b0, dvs_q} : '0);
    div_sh   = {acc_hi_q, acc_lo_q[WIDTH-1]};
    div_diff = div_sh - {1'b0, dvs_q};
    step_hi  = mul_sum[WIDTH:1];
    step_lo  = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
    if (div_q) begin
      if (!div_diff[WIDTH]) begin
        step_hi = div_diff[WIDTH-1:0];
        step_lo = {acc_lo_q[WIDTH-2:0], 1'b1};
      end else begin
        step_hi = div_sh[WIDTH-1:0];
        step_lo = {acc_lo_q[WIDTH-2:0], 1'b0};
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    dvs_d    = dvs_q;
    div_d    = div_q;
    dbz_d    = dbz_q;
    res_d    = res_q;
    hi_d     = hi_q;
    zero_d   = zero_q;
    done_d   = 1'b0;
    if (accept) begin
      dbz_d = 1'b0;
      if (is_iter && con[0] && (op2 == '0)) begin
        res_d  = '1;
        hi_d   = op1;
        zero_d = 1'b0;
        dbz_d  = 1'b1;
        done_d = 1'b1;
      end else if (is_iter) begin
        state_d  = RUN;
        cnt_d    = '0;
        acc_hi_d = '0;
        acc_lo_d = op1;
        dvs_d    = op2;
        div_d    = con[0];
      end else begin
        res_d  = alu_res;
        hi_d   = '0;
        zero_d = (alu_res == '0);
        done_d = 1'b1;
      end
    end else if (state_q == RUN) begin
      acc_hi_d = step_hi;
      acc_lo_d = step_lo;
      cnt_d    = cnt_q + 1'b1;
      if (cnt_q == CNT_W'(WIDTH - 1)) begin
        state_d = IDLE;
        res_d   = step_lo;
        hi_d    = step_hi;
        zero_d  = (step_lo == '0);
        done_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      dvs_q    <= '0;
      div_q    <= 1'b0;
      dbz_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      dvs_q    <= dvs_d;
      div_q    <= div_d;
      dbz_q    <= dbz_d;
    end
  end

  assign busy        = (state_q == RUN);
  assign div_by_zero = dbz_q;
`else
  assign accept = start;

  always_comb begin
    res_d  = res_q;
    hi_d   = hi_q;
    zero_d = zero_q;
    done_d = 1'b0;
    if (accept) begin
      res_d  = alu_res;
      hi_d   = '0;
      zero_d = (alu_res == '0);
      done_d = 1'b1;
    end
  end

  assign busy        = 1'b0;
  assign div_by_zero = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      res_q  <= '0;
      hi_q   <= '0;
      zero_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      res_q  <= res_d;
      hi_q   <= hi_d;
      zero_q <= zero_d;
      done_q <= done_d;
    end
  end

  assign result    = res_q;
  assign result_hi = hi_q;
  assign zero      = zero_q;
  assign done      = done_q;

endmodule
